// File: rtl/tx_share_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// tx_share_arbiter_pkg
// Shared definitions for the UART transmitter share arbiter:
//   - FSM state encoding (IDLE, LOAD, SEND, DONE)
//   - default number of requesters and default per-frame timeout
// No ports; imported by the interface, the rr_pick sub-module and the top.
// -----------------------------------------------------------------------------
package tx_share_arbiter_pkg;

  localparam int DEF_NUM_REQ        = 4;
  localparam int DEF_TIMEOUT_CYCLES = 200000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/tx_share_arbiter_if.sv
// -----------------------------------------------------------------------------
// tx_share_arbiter_if
// Bundles the requester side (REQ, REQ_DATA, ACK, BUSY, ERR) and the
// transmitter side (TX_En_Sig, TX_Data, TX_Done_Sig) of the arbiter.
//   master : requesters + transmitter model (drive REQ, REQ_DATA, TX_Done_Sig)
//   slave  : the arbiter (drives ACK, BUSY, TX_En_Sig, TX_Data, ERR)
// NUM_REQ must match the arbiter's NUM_REQ.
// -----------------------------------------------------------------------------
interface tx_share_arbiter_if
  import tx_share_arbiter_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ
);

  logic [NUM_REQ-1:0]   REQ;
  logic [8*NUM_REQ-1:0] REQ_DATA;
  logic [NUM_REQ-1:0]   ACK;
  logic                 BUSY;
  logic                 TX_En_Sig;
  logic [7:0]           TX_Data;
  logic                 TX_Done_Sig;
  logic                 ERR;

  modport master (
    output REQ, REQ_DATA, TX_Done_Sig,
    input  ACK, BUSY, TX_En_Sig, TX_Data, ERR
  );

  modport slave (
    input  REQ, REQ_DATA, TX_Done_Sig,
    output ACK, BUSY, TX_En_Sig, TX_Data, ERR
  );

endinterface

// File: rtl/tx_share_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational rotate-priority select: returns the first asserted request
// at or after the pointer, wrapping at NUM_REQ.
// Ports:
//   req   [NUM_REQ-1:0] in   request vector
//   ptr   [IDX_W-1:0]   in   round-robin start index (0..NUM_REQ-1)
//   grant [NUM_REQ-1:0] out  one-hot winner (all zero when no request)
//   idx   [IDX_W-1:0]   out  binary winner index
//   valid               out  at least one request present
// -----------------------------------------------------------------------------
module rr_pick
  import tx_share_arbiter_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx,
  output logic               valid
);

  // One extra bit so ptr + offset cannot overflow before the explicit wrap.
  localparam int SW = IDX_W + 1;

  always_comb begin
    logic [SW-1:0]    sum;
    logic [IDX_W-1:0] cand;
    // NOTE: every output gets a default before the loop so no path leaves a
    // value unassigned, which would otherwise infer a latch.
    sum   = '0;
    cand  = '0;
    grant = '0;
    idx   = '0;
    valid = 1'b0;
    for (int off = 0; off < NUM_REQ; off++) begin
      sum = {1'b0, ptr} + SW'(off);
      if (sum >= SW'(NUM_REQ)) sum = sum - SW'(NUM_REQ);
      cand = sum[IDX_W-1:0];
      if (!valid && req[cand]) begin
        valid       = 1'b1;
        idx         = cand;
        grant[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tx_share_arbiter.sv
// -----------------------------------------------------------------------------
// tx_share_arbiter
// Round-robin arbiter sharing one UART transmitter between NUM_REQ requesters.
// FSM IDLE -> LOAD -> SEND -> DONE -> IDLE; all outputs registered.
// Ports:
//   CLK   in  system clock, rising edge
//   RSTn  in  asynchronous active-low reset
//   bus   tx_share_arbiter_if.slave
//         REQ/REQ_DATA in, ACK/BUSY/ERR out (requester side)
//         TX_En_Sig/TX_Data out, TX_Done_Sig in (transmitter side)
// Build option: define TX_ARB_TIMEOUT_EN to abort a frame after
// TIMEOUT_CYCLES SEND cycles without TX_Done_Sig (ACK and ERR pulse together).
// Without it SEND waits indefinitely and ERR is tied low.
// -----------------------------------------------------------------------------
module tx_share_arbiter
  import tx_share_arbiter_pkg::*;
#(
  parameter int NUM_REQ        = DEF_NUM_REQ,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic              CLK,
  input  logic              RSTn,
  tx_share_arbiter_if.slave bus
);

  localparam int IDX_W = $clog2(NUM_REQ);

  state_t             state;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   grant_idx;
  logic [NUM_REQ-1:0] grant_oh;
  logic [NUM_REQ-1:0] ack;
  logic               busy;
  logic               tx_en;
  logic [7:0]         tx_data;

  logic [IDX_W-1:0]   pick_idx;
  logic [NUM_REQ-1:0] pick_oh;
  logic               pick_valid;
  logic [IDX_W-1:0]   next_ptr;

`ifdef TX_ARB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt;
  logic             err;
`else
  // TIMEOUT_CYCLES has no function without the timeout feature.
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req   (bus.REQ),
    .ptr   (rr_ptr),
    .grant (pick_oh),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  // The requester just served drops to lowest priority.
  assign next_ptr = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      grant_idx <= '0;
      grant_oh  <= '0;
      ack       <= '0;
      busy      <= 1'b0;
      tx_en     <= 1'b0;
      tx_data   <= 8'h00;
`ifdef TX_ARB_TIMEOUT_EN
      tmo_cnt   <= '0;
      err       <= 1'b0;
`endif
    end else begin
      // ACK/ERR are single-cycle pulses; DONE is the only state that sets them
      // (on entry), so they clear on the following edge.
      ack <= '0;
`ifdef TX_ARB_TIMEOUT_EN
      err <= 1'b0;
`endif
      case (state)
        IDLE: begin
          // Grant is frozen here so later REQ changes cannot move it.
          if (pick_valid) begin
            grant_idx <= pick_idx;
            grant_oh  <= pick_oh;
            busy      <= 1'b1;
            state     <= LOAD;
          end
        end
        LOAD: begin
          tx_data <= bus.REQ_DATA[{grant_idx, 3'b000} +: 8];
          tx_en   <= 1'b1;
`ifdef TX_ARB_TIMEOUT_EN
          tmo_cnt <= '0;
`endif
          state   <= SEND;
        end
        SEND: begin
          // Enable drops on the same edge done is seen; the transmitter's
          // cleanup cycle overlaps the enable still being high.
          if (bus.TX_Done_Sig) begin
            tx_en <= 1'b0;
            ack   <= grant_oh;
            state <= DONE;
          end
`ifdef TX_ARB_TIMEOUT_EN
          else if (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
            tx_en <= 1'b0;
            ack   <= grant_oh;
            err   <= 1'b1;
            state <= DONE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
`endif
        end
        DONE: begin
          busy   <= 1'b0;
          rr_ptr <= next_ptr;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ACK       = ack;
  assign bus.BUSY      = busy;
  assign bus.TX_En_Sig = tx_en;
  assign bus.TX_Data   = tx_data;
`ifdef TX_ARB_TIMEOUT_EN
  assign bus.ERR       = err;
`else
  assign bus.ERR       = 1'b0;
`endif

endmodule

// File: tb/tb_tx_share_arbiter.sv
// -----------------------------------------------------------------------------
// tb_tx_share_arbiter
// Self-checking bench for tx_share_arbiter (NUM_REQ=4, TIMEOUT_CYCLES=50).
// Expected grants are queued when requests are raised and compared when ACK
// pulses. A transmitter model pulses TX_Done_Sig tx_delay cycles after
// TX_En_Sig rises. The timeout scenario runs when TX_ARB_TIMEOUT_EN is defined.
// -----------------------------------------------------------------------------
module tb_tx_share_arbiter;

  localparam int NREQ = 4;
  localparam int TMO  = 50;

  typedef struct {
    int         idx;
    logic [7:0] data;
    logic       err;
    int         lat;
  } exp_t;

  logic clk;
  logic rstn;

  tx_share_arbiter_if #(.NUM_REQ(NREQ)) bus ();

  tx_share_arbiter #(
    .NUM_REQ        (NREQ),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .CLK  (clk),
    .RSTn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   checks      = 0;
  int   fails       = 0;
  int   cycle       = 0;
  int   rise_cycle  = 0;
  int   acks_seen   = 0;
  int   tx_delay    = 4;
  int   en_cnt      = 0;
  logic tx_hold     = 1'b0;
  logic stray_done  = 1'b0;
  logic drop_on_ack = 1'b1;
  logic prev_en     = 1'b0;
  logic [NREQ-1:0] prev_ack = '0;
  exp_t exp_q[$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cycle);
    end
  endtask

  // Transmitter model: done pulse after tx_delay enabled cycles; optional
  // stray pulses while disabled must be ignored by the arbiter.
  always @(negedge clk) begin
    if (!rstn || !bus.TX_En_Sig) begin
      en_cnt = 0;
      bus.TX_Done_Sig = stray_done;
    end else begin
      en_cnt++;
      bus.TX_Done_Sig = (!tx_hold && en_cnt == tx_delay);
    end
  end

  task automatic push_exp(input int idx, input logic [7:0] d, input logic e, input int lat);
    exp_t x;
    x.idx = idx; x.data = d; x.err = e; x.lat = lat;
    exp_q.push_back(x);
  endtask

  task automatic set_data(input int i, input logic [7:0] b);
    bus.REQ_DATA[i*8 +: 8] = b;
  endtask

  // One clock: sample on the falling edge and run the scoreboard.
  task automatic step();
    exp_t e;
    @(negedge clk);
    cycle++;
    if (prev_ack != '0) check("ack_single", 32'(bus.ACK), 32'(0));
    if (bus.ACK == '0) check("err_quiet", 32'(bus.ERR), 32'(0));
    if (bus.TX_En_Sig && !prev_en) begin
      rise_cycle = cycle;
      if (exp_q.size() == 0) check("en_unexpected", 32'(bus.TX_En_Sig), 32'(0));
    end
    if (bus.TX_En_Sig && exp_q.size() != 0) check("tx_data", 32'(bus.TX_Data), 32'(exp_q[0].data));
    if (bus.ACK != '0) begin
      acks_seen++;
      if (exp_q.size() == 0) begin
        check("ack_unexpected", 32'(bus.ACK), 32'(0));
      end else begin
        e = exp_q.pop_front();
        check("ack_onehot", 32'(bus.ACK), 32'(1) << e.idx);
        check("ack_data", 32'(bus.TX_Data), 32'(e.data));
        check("ack_err", 32'(bus.ERR), 32'(e.err));
        check("ack_busy", 32'(bus.BUSY), 32'(1));
        check("ack_txen", 32'(bus.TX_En_Sig), 32'(0));
        check("ack_latency", 32'(cycle - rise_cycle), 32'(e.lat));
        if (drop_on_ack) bus.REQ[e.idx] = 1'b0;
      end
    end
    prev_ack = bus.ACK;
    prev_en  = bus.TX_En_Sig;
  endtask

  task automatic wait_acks(input int n, input int budget);
    int target;
    int k;
    target = acks_seen + n;
    k = 0;
    while (acks_seen < target && k < budget) begin
      step();
      k++;
    end
    check("ack_wait", 32'(acks_seen), 32'(target));
  endtask

  task automatic wait_en(input int budget);
    int k;
    k = 0;
    while (!bus.TX_En_Sig && k < budget) begin
      step();
      k++;
    end
    check("en_wait", 32'(bus.TX_En_Sig), 32'(1));
  endtask

  task automatic check_reset_vals(input string pfx);
    check({pfx, "_txen"}, 32'(bus.TX_En_Sig), 32'(0));
    check({pfx, "_txdata"}, 32'(bus.TX_Data), 32'(8'h00));
    check({pfx, "_ack"}, 32'(bus.ACK), 32'(0));
    check({pfx, "_busy"}, 32'(bus.BUSY), 32'(0));
    check({pfx, "_err"}, 32'(bus.ERR), 32'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    rstn         = 1'b1;
    bus.REQ      = '0;
    bus.REQ_DATA = '0;
    #1 rstn = 1'b0;
    repeat (3) step();
    check_reset_vals("rst");
    rstn = 1'b1;
    repeat (2) step();

    // Done pulses with nothing granted change nothing.
    stray_done = 1'b1;
    repeat (3) step();
    stray_done = 1'b0;
    step();
    check("stray_busy", 32'(bus.BUSY), 32'(0));
    check("stray_txen", 32'(bus.TX_En_Sig), 32'(0));

    // Single request: enable 2 cycles after REQ, done after 100 cycles.
    tx_delay = 100;
    set_data(1, 8'hA5);
    bus.REQ = 4'b0010;
    push_exp(1, 8'hA5, 1'b0, tx_delay);
    step();
    check("lat1_txen", 32'(bus.TX_En_Sig), 32'(0));
    check("lat1_busy", 32'(bus.BUSY), 32'(1));
    step();
    check("lat2_txen", 32'(bus.TX_En_Sig), 32'(1));
    check("lat2_data", 32'(bus.TX_Data), 32'(8'hA5));
    wait_acks(1, 300);

    // Pointer now 2: serve 2, change its data and add REQ 3/0 mid-SEND.
    // Grant and TX_Data must hold; then pointer 3 wraps: serve 3 then 0.
    tx_delay = 4;
    set_data(2, 8'h5C);
    bus.REQ = 4'b0100;
    push_exp(2, 8'h5C, 1'b0, tx_delay);
    wait_en(20);
    set_data(2, 8'hFF);
    set_data(3, 8'hD3);
    set_data(0, 8'hD0);
    bus.REQ = 4'b1101;
    push_exp(3, 8'hD3, 1'b0, tx_delay);
    push_exp(0, 8'hD0, 1'b0, tx_delay);
    wait_acks(3, 100);

    // Reset mid-SEND: no ACK, reset values, requester re-served afterwards.
    tx_hold = 1'b1;
    set_data(1, 8'h77);
    bus.REQ = 4'b0010;
    push_exp(1, 8'h77, 1'b0, tx_delay);
    wait_en(20);
    repeat (5) step();
    rstn = 1'b0;
    step();
    check_reset_vals("rst_mid");
    exp_q.delete(0);
    step();
    rstn    = 1'b1;
    tx_hold = 1'b0;
    push_exp(1, 8'h77, 1'b0, tx_delay);
    wait_acks(1, 50);

    // Round robin from pointer 0 with all requests held.
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    step();
    drop_on_ack = 1'b0;
    for (int i = 0; i < NREQ; i++) set_data(i, 8'h10 + 8'(i));
    bus.REQ = 4'b1111;
    for (int i = 0; i < 5; i++) push_exp(i % NREQ, 8'h10 + 8'(i % NREQ), 1'b0, tx_delay);
    wait_acks(5, 200);
    bus.REQ = '0;
    drop_on_ack = 1'b1;
    repeat (4) step();

`ifdef TX_ARB_TIMEOUT_EN
    // No done pulse: abort after TMO SEND cycles with ERR and ACK together.
    tx_hold = 1'b1;
    set_data(2, 8'h9E);
    bus.REQ = 4'b0100;
    push_exp(2, 8'h9E, 1'b1, TMO);
    wait_acks(1, TMO + 40);
    tx_hold = 1'b0;
    repeat (4) step();
`endif

    check("end_busy", 32'(bus.BUSY), 32'(0));
    check("end_queue", 32'(exp_q.size()), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/tx_share_arbiter.md
TX_SHARE_ARBITER -- requirements
Module: tx_share_arbiter

Interface
REQ-001 Parameter NUM_REQ, 4, number of requesters sharing one UART transmitter (2..8).
REQ-002 Parameter TIMEOUT_CYCLES, 200000, CLK cycles allowed per frame before abort (timeout build only).
REQ-003 CLK  input  1  system clock; all state updates on rising edge.
REQ-004 RSTn  input  1  reset, asynchronous, active-low.
REQ-005 REQ  input  NUM_REQ  per-requester send request, level, held until ACK.
REQ-006 REQ_DATA  input  8*NUM_REQ  per-requester byte; slice i belongs to REQ[i].
REQ-007 ACK  output  NUM_REQ  one-cycle pulse to requester i when its byte completes or aborts.
REQ-008 BUSY  output  1  high from grant until ACK cycle inclusive.
REQ-009 TX_En_Sig  output  1  transmitter enable, registered.
REQ-010 TX_Data  output  8  byte to transmitter, registered, stable while TX_En_Sig high.
REQ-011 TX_Done_Sig  input  1  transmitter frame-complete pulse.
REQ-012 ERR  output  1  one-cycle pulse coincident with ACK on timeout abort (timeout build only; tied 0 otherwise).

Function
REQ-013 The FSM SHALL have states IDLE, LOAD, SEND, DONE.
- IDLE: any REQ bit high -> LOAD next edge; grant = first requester at or after RR pointer, wrapping.
- LOAD: latch REQ_DATA of grantee into TX_Data, record grant index -> SEND; TX_En_Sig rises on this edge.
- SEND: hold TX_En_Sig=1, TX_Data unchanged; TX_Done_Sig sampled high -> DONE.
- DONE: ACK[grant]=1 for exactly one cycle -> IDLE.
REQ-014 TX_En_Sig SHALL deassert on the same edge TX_Done_Sig is sampled high, so the transmitter completes its final cleanup cycle while still enabled.
REQ-015 RR pointer SHALL update in DONE to (grant+1) mod NUM_REQ; a requester just served has lowest priority next arbitration.
REQ-016 REQ changes during LOAD/SEND/DONE SHALL NOT alter the grant or TX_Data.
REQ-017 Request-to-TX_En_Sig latency SHALL be 2 cycles from IDLE; back-to-back frames separated by exactly 2 idle cycles (DONE, IDLE).
REQ-018 A requester whose REQ stays high after ACK SHALL be treated as a new request.
REQ-019 TX_Done_Sig outside SEND SHALL be ignored.
REQ-020 Grant index arithmetic SHALL use ceil(log2(NUM_REQ)) bits with explicit wrap at NUM_REQ.

Reset
REQ-021 On RSTn low: state IDLE, RR pointer 0, TX_En_Sig 0, TX_Data 8'h00, ACK 0, BUSY 0, ERR 0, timeout counter 0.
REQ-022 Reset mid-frame SHALL abort without ACK; the in-flight requester re-arbitrates after release.

Configuration
REQ-023 Macro TX_ARB_TIMEOUT_EN defined: counter runs in SEND; at TIMEOUT_CYCLES without TX_Done_Sig, FSM goes to DONE, TX_En_Sig drops, ACK and ERR pulse together.
REQ-024 Macro TX_ARB_TIMEOUT_EN undefined: no counter, SEND waits indefinitely, ERR constant 0, parameter TIMEOUT_CYCLES unused.

Structure
REQ-025 Shared package SHALL hold the state encoding constants (IDLE/LOAD/SEND/DONE) and the default NUM_REQ/TIMEOUT_CYCLES values.
REQ-026 Sub-module rr_pick (combinational rotate-priority select: REQ, pointer -> one-hot grant, index, valid) SHALL be instantiated once.

Verification
REQ-027 Single request: REQ=4'b0010, REQ_DATA[15:8]=8'hA5, transmitter model done after 100 cycles -> TX_Data=8'hA5, TX_En_Sig high 2 cycles after REQ, ACK=4'b0010 one cycle after done.
REQ-028 Round robin: REQ=4'b1111 held, data 8'h10/11/12/13 -> serve order 0,1,2,3,0; each ACK single-cycle.
REQ-029 Wrap: pointer at 3, REQ=4'b1001 -> requester 3 served, then requester 0.
REQ-030 Data stability: change REQ_DATA of grantee during SEND -> TX_Data unchanged until ACK.
REQ-031 Timeout (TX_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=50): no TX_Done_Sig -> after 50 SEND cycles ERR=1 and ACK pulse together, TX_En_Sig 0.
REQ-032 Reset mid-SEND -> all outputs at reset values, no ACK; requester served after RSTn release.
